// File: rtl/core_rst_seq.sv
// Core reset sequencer: holds the core in reset for a minimum time, captures the
// boot vector on release, and drains bus traffic (with timeout) before re-asserting.
module core_rst_seq #(
   parameter int XLEN            = 32,
   parameter int HOLD_CYCLES     = 16,
   parameter int QUIESCE_TIMEOUT = 256
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rstn_req,
   input  logic [XLEN-1:0] bootvec_in,
   input  logic            quiesce_ack,
   output logic            core_rstn,
   output logic [XLEN-1:0] core_bootvec,
   output logic            quiesce_req,
   output logic            timeout_flag,
   output logic [1:0]      state_o
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int TW = $clog2(QUIESCE_TIMEOUT);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
   localparam logic [TW-1:0] TMO_LAST = TW'(QUIESCE_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IN_RST = 2'd0,
      RUN    = 2'd1,
      DRAIN  = 2'd2,
      UNUSED = 2'd3
   } state_t;

   state_t          state, state_n;
   logic [HW-1:0]   hold_cnt, hold_n;
   logic [TW-1:0]   tmo_cnt, tmo_n;
   logic            rstn_n, qreq_n, tf_n;
   logic [XLEN-1:0] bv_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IN_RST;
         hold_cnt     <= '0;
         tmo_cnt      <= '0;
         core_rstn    <= 1'b0;
         core_bootvec <= '0;
         quiesce_req  <= 1'b0;
         timeout_flag <= 1'b0;
      end else begin
         state        <= state_n;
         hold_cnt     <= hold_n;
         tmo_cnt      <= tmo_n;
         core_rstn    <= rstn_n;
         core_bootvec <= bv_n;
         quiesce_req  <= qreq_n;
         timeout_flag <= tf_n;
      end
   end

   always_comb begin
      state_n = state;
      hold_n  = hold_cnt;
      tmo_n   = tmo_cnt;
      rstn_n  = core_rstn;
      bv_n    = core_bootvec;
      qreq_n  = quiesce_req;
      tf_n    = timeout_flag;
      unique case (state)
         IN_RST: begin
            rstn_n = 1'b0;
            qreq_n = 1'b0;
            if (hold_cnt != HOLD_MAX) hold_n = hold_cnt + 1'b1;
            if (hold_cnt == HOLD_MAX && rstn_req) begin
               state_n = RUN;
               rstn_n  = 1'b1;
               bv_n    = bootvec_in;
            end
         end
         RUN: begin
            rstn_n = 1'b1;
            qreq_n = 1'b0;
            if (!rstn_req) begin
               state_n = DRAIN;
               qreq_n  = 1'b1;
               tmo_n   = '0;
            end
         end
         DRAIN: begin
            // Committed once entered: rstn_req is not looked at here; ack beats timeout.
            rstn_n = 1'b1;
            qreq_n = 1'b1;
            tmo_n  = tmo_cnt + 1'b1;
            if (quiesce_ack || tmo_cnt == TMO_LAST) begin
               state_n = IN_RST;
               rstn_n  = 1'b0;
               qreq_n  = 1'b0;
               hold_n  = '0;
               tmo_n   = '0;
               if (!quiesce_ack) tf_n = 1'b1;
            end
         end
         default: begin
            state_n = IN_RST;
            rstn_n  = 1'b0;
            qreq_n  = 1'b0;
            hold_n  = '0;
            tmo_n   = '0;
         end
      endcase
   end

   assign state_o = state;

endmodule

// File: tb/tb_core_rst_seq.sv
// Directed bench for core_rst_seq: a vector table of {inputs, cycles, expected outputs}
// plus hand-written sequences for per-edge release timing and reset mid-drain.
module tb_core_rst_seq;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst, rstn_req, quiesce_ack;
   logic [XLEN-1:0] bootvec_in;
   logic            core_rstn, quiesce_req, timeout_flag;
   logic [XLEN-1:0] core_bootvec;
   logic [1:0]      state_o;

   int total = 0;
   int bad   = 0;

   core_rst_seq #(.XLEN(XLEN), .HOLD_CYCLES(16), .QUIESCE_TIMEOUT(256)) dut (
      .clk(clk), .rst(rst), .rstn_req(rstn_req), .bootvec_in(bootvec_in),
      .quiesce_ack(quiesce_ack), .core_rstn(core_rstn), .core_bootvec(core_bootvec),
      .quiesce_req(quiesce_req), .timeout_flag(timeout_flag), .state_o(state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          n;
      logic        rst, req, ack;
      logic [31:0] bv;
      logic        e_rstn, e_q, e_tf;
      logic [1:0]  e_st;
      logic [31:0] e_bv;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(int n, logic r, logic rq, logic a, logic [31:0] bv,
                               logic er, logic eq, logic et, logic [1:0] es, logic [31:0] ebv);
      vec_t t;
      t.n = n; t.rst = r; t.req = rq; t.ack = a; t.bv = bv;
      t.e_rstn = er; t.e_q = eq; t.e_tf = et; t.e_st = es; t.e_bv = ebv;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic er, input logic eq, input logic et,
                          input logic [1:0] es, input logic [31:0] ebv);
      chk({tag, ".core_rstn"},    {31'd0, core_rstn},    {31'd0, er});
      chk({tag, ".quiesce_req"},  {31'd0, quiesce_req},  {31'd0, eq});
      chk({tag, ".timeout_flag"}, {31'd0, timeout_flag}, {31'd0, et});
      chk({tag, ".state_o"},      {30'd0, state_o},      {30'd0, es});
      chk({tag, ".core_bootvec"}, core_bootvec,          ebv);
   endtask

   localparam logic [31:0] BV0 = 32'h8000_0000;
   localparam logic [31:0] BV1 = 32'h1234_5678;
   localparam logic [31:0] BV2 = 32'h2000_0000;

   initial begin
      rst = 1'b1; rstn_req = 1'b1; quiesce_ack = 1'b0; bootvec_in = BV0;

      // Power-up release, checked edge by edge
      step(2);
      chk_all("pwr.reset", 0, 0, 0, 2'd0, 32'h0);
      rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         step(1);
         chk($sformatf("pwr.edge%0d.core_rstn", k), {31'd0, core_rstn}, 32'd0);
      end
      step(1);
      chk_all("pwr.edge17", 1, 0, 0, 2'd1, BV0);

      //              n    rst req ack bv      rstn q tf st    bv
      vecs.push_back(mk(2,   1, 1, 0, BV0,     0, 0, 0, 2'd0, 32'h0)); // reset
      vecs.push_back(mk(16,  0, 1, 0, BV0,     0, 0, 0, 2'd0, 32'h0)); // edges 1..16
      vecs.push_back(mk(1,   0, 1, 0, BV0,     1, 0, 0, 2'd1, BV0));   // edge 17 release
      vecs.push_back(mk(3,   0, 1, 0, BV1,     1, 0, 0, 2'd1, BV0));   // bootvec ignored in RUN
      vecs.push_back(mk(1,   0, 0, 0, BV1,     1, 1, 0, 2'd2, BV0));   // enter DRAIN
      vecs.push_back(mk(4,   0, 0, 0, BV1,     1, 1, 0, 2'd2, BV0));
      vecs.push_back(mk(1,   0, 0, 1, BV1,     0, 0, 0, 2'd0, BV0));   // ack -> clean drain
      vecs.push_back(mk(16,  0, 1, 0, BV1,     0, 0, 0, 2'd0, BV0));   // full hold
      vecs.push_back(mk(1,   0, 1, 0, BV1,     1, 0, 0, 2'd1, BV1));   // re-release, new vector
      vecs.push_back(mk(1,   0, 0, 0, BV1,     1, 1, 0, 2'd2, BV1));   // enter DRAIN
      vecs.push_back(mk(255, 0, 0, 0, BV1,     1, 1, 0, 2'd2, BV1));
      vecs.push_back(mk(1,   0, 0, 0, BV1,     0, 0, 1, 2'd0, BV1));   // timeout at 256th edge
      vecs.push_back(mk(40,  0, 0, 0, BV1,     0, 0, 1, 2'd0, BV1));   // late release wait
      vecs.push_back(mk(1,   0, 1, 0, BV2,     1, 0, 1, 2'd1, BV2));   // first edge sampling req=1
      vecs.push_back(mk(1,   1, 1, 0, BV2,     0, 0, 0, 2'd0, 32'h0)); // rst clears sticky flag
      vecs.push_back(mk(17,  0, 1, 0, BV2,     1, 0, 0, 2'd1, BV2));
      vecs.push_back(mk(1,   0, 0, 0, BV2,     1, 1, 0, 2'd2, BV2));
      vecs.push_back(mk(255, 0, 0, 0, BV2,     1, 1, 0, 2'd2, BV2));
      vecs.push_back(mk(1,   0, 0, 1, BV2,     0, 0, 0, 2'd0, BV2));   // ack and timeout same edge
      vecs.push_back(mk(17,  0, 1, 1, BV2,     1, 0, 0, 2'd1, BV2));
      vecs.push_back(mk(1,   0, 0, 1, BV2,     1, 1, 0, 2'd2, BV2));   // ack pre-asserted
      vecs.push_back(mk(1,   0, 1, 1, BV2,     0, 0, 0, 2'd0, BV2));   // DRAIN lasts one cycle
      vecs.push_back(mk(17,  0, 1, 0, BV2,     1, 0, 0, 2'd1, BV2));
      vecs.push_back(mk(1,   0, 0, 0, BV2,     1, 1, 0, 2'd2, BV2));   // 1-cycle req pulse
      vecs.push_back(mk(3,   0, 1, 0, BV2,     1, 1, 0, 2'd2, BV2));   // committed drain
      vecs.push_back(mk(1,   0, 1, 1, BV2,     0, 0, 0, 2'd0, BV2));
      vecs.push_back(mk(16,  0, 1, 0, BV2,     0, 0, 0, 2'd0, BV2));   // still full hold
      vecs.push_back(mk(1,   0, 1, 0, BV2,     1, 0, 0, 2'd1, BV2));

      foreach (vecs[i]) begin
         rst = vecs[i].rst; rstn_req = vecs[i].req;
         quiesce_ack = vecs[i].ack; bootvec_in = vecs[i].bv;
         step(vecs[i].n);
         chk_all($sformatf("vec%0d", i), vecs[i].e_rstn, vecs[i].e_q, vecs[i].e_tf,
                 vecs[i].e_st, vecs[i].e_bv);
      end

      // Reset mid-DRAIN: quiesce_req drops without any ack
      rstn_req = 1'b0; quiesce_ack = 1'b0;
      step(1);
      chk_all("middrain.entry", 1, 1, 0, 2'd2, BV2);
      step(3);
      chk_all("middrain.3", 1, 1, 0, 2'd2, BV2);
      rst = 1'b1;
      step(1);
      chk_all("middrain.rst", 0, 0, 0, 2'd0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/core_rst_seq.md
# core_rst_seq

Core reset sequencer sitting directly downstream of the configuration register block. It turns the software-written core reset request and boot vector into a clean core reset. Release waits for a guaranteed minimum hold time, and the boot vector is captured at the release edge. Before assertion, the core's bus traffic is drained via a quiesce handshake with a timeout.

## Interface
Parameters:
- XLEN, 32, width of boot vector
- HOLD_CYCLES, 16, minimum cycles core reset is held low before release; legal range ≥1
- QUIESCE_TIMEOUT, 256, maximum cycles spent waiting for quiesce_ack; legal range ≥2

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous active-high reset
- rstn_req  input  1  software core reset request level from config registers; 0 = hold core in reset, 1 = run
- bootvec_in  input  XLEN  boot vector from config registers
- quiesce_ack  input  1  core/bus fabric reports no outstanding transactions
- core_rstn  output  1  registered active-low reset to core
- core_bootvec  output  XLEN  registered boot vector presented to core
- quiesce_req  output  1  registered request to stop issuing bus transactions
- timeout_flag  output  1  sticky; set when a drain ended by timeout
- state_o  output  2  current FSM state: 0 IN_RST, 1 RUN, 2 DRAIN (3 unused)

## Operation
- States:
  - IN_RST: core_rstn=0, quiesce_req=0.
    - hold_cnt increments each cycle, saturating at HOLD_CYCLES.
    - When hold_cnt==HOLD_CYCLES and rstn_req==1, go to RUN. On that edge, core_rstn<=1 and core_bootvec<=bootvec_in.
  - RUN: core_rstn=1. When rstn_req==0, go to DRAIN. On that edge, quiesce_req<=1 and tmo_cnt<=0.
  - DRAIN: core_rstn=1, quiesce_req=1, tmo_cnt increments each cycle.
    - If quiesce_ack==1, go to IN_RST.
    - Else if tmo_cnt==QUIESCE_TIMEOUT-1, go to IN_RST and set timeout_flag.
    - On exit: core_rstn<=0, quiesce_req<=0, hold_cnt<=0.
- DRAIN is committed: rstn_req returning to 1 during DRAIN does not abort it. The core still passes through IN_RST for the full HOLD_CYCLES.
- Ack and timeout on the same edge: the ack wins; timeout_flag is not set.
- quiesce_ack already high on DRAIN entry: the first DRAIN edge exits, so DRAIN lasts exactly 1 cycle.
- core_bootvec changes only on the IN_RST→RUN edge. It holds its value through RUN, DRAIN and IN_RST; bootvec_in changes at any other time are ignored.
- timeout_flag clears only on rst.
- Counter widths:
  - hold_cnt: $clog2(HOLD_CYCLES+1) bits, saturating, never wraps.
  - tmo_cnt: $clog2(QUIESCE_TIMEOUT) bits; never reaches wrap because of the exit condition.
- State encoding 3 is unreachable; if entered, the next edge goes to IN_RST with IN_RST outputs.

## Timing
- Reset values (rst sampled high): state IN_RST, hold_cnt 0, tmo_cnt 0, core_rstn 0, core_bootvec 0, quiesce_req 0, timeout_flag 0.
- rst asserted mid-operation, from any state, takes effect on that edge. quiesce_req drops without waiting for ack.
- Edge numbering: edge k is the k-th rising edge after rst sampled low, so hold_cnt==k after edge k (k ≤ HOLD_CYCLES).
- Release latency: with rstn_req=1 throughout, core_rstn rises at edge HOLD_CYCLES+1.
- If rstn_req rises later, core_rstn rises on the first edge that samples rstn_req=1 with hold_cnt saturated.
- Assertion latency: rstn_req sampled 0 in RUN → quiesce_req=1 at that edge.
  - quiesce_ack sampled 1 at the n-th DRAIN edge → core_rstn=0 and quiesce_req=0 at that same edge.
- Timeout: with no ack, core_rstn falls at the QUIESCE_TIMEOUT-th edge after DRAIN entry; timeout_flag rises on the same edge.
- All outputs are registered; no combinational input→output paths.

## Test plan
- Power-up release: HOLD_CYCLES=16, rstn_req=1, bootvec_in=0x8000_0000 held from rst deassert → core_rstn=0 through edge 16, 1 at edge 17; core_bootvec=0x8000_0000; state_o=1.
- Late software release: rstn_req=0 for 40 cycles, then bootvec_in=0x2000_0000 and rstn_req=1 → core_rstn rises on the first edge sampling rstn_req=1; core_bootvec=0x2000_0000.
- Clean drain: from RUN drop rstn_req; quiesce_ack asserted 5 cycles later → quiesce_req high 5 cycles, core_rstn falls on the ack-sampling edge, timeout_flag=0; re-release after ≥16 cycles.
- Drain timeout: QUIESCE_TIMEOUT=256, quiesce_ack tied 0 → core_rstn falls exactly 256 edges after DRAIN entry; timeout_flag=1 and stays 1 through later RUN.
- Edge cases:
  - Ack and timeout on the same edge → timeout_flag stays 0.
  - rstn_req pulsed 0 for 1 cycle in RUN → full DRAIN plus 16-cycle IN_RST.
  - quiesce_ack pre-asserted → DRAIN lasts 1 cycle.
- Reset mid-DRAIN: rst asserted 3 cycles into DRAIN → next edge gives core_rstn=0, quiesce_req=0, core_bootvec=0, timeout_flag=0, state_o=0.
